// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver for the TX mode/rate FSM: recovers command bytes, holds the
// last good byte on odata, and pulses oVALID / oFRAME_ERR for one cycle each.
module uart_rx_cmd #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iRX,
  output logic [7:0] odata,
  output logic       oVALID,
  output logic       oFRAME_ERR,
  output logic       oBUSY
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic             r_sync1, r_sync2;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitidx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             w_rx_s;

  // Synchroniser resets to the idle-high line level so reset release is not
  // mistaken for a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= iRX;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // NOTE: every register in this block uses <= so all of them update from the
  // same pre-edge values; a blocking assignment here would reorder the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bitidx    <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_cnt       <= r_cnt + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state  <= S_DATA;
              r_bitidx <= '0;
            end else begin
              r_state  <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt    <= '0;
            r_shift  <= {w_rx_s, r_shift[7:1]};
            r_bitidx <= r_bitidx + 3'd1;
            if (r_bitidx == 3'd7) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          // A break or stuck-low line must go high before a new start is armed.
          r_cnt <= '0;
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign odata      = r_data;
  assign oVALID     = r_valid;
  assign oFRAME_ERR = r_frame_err;
  assign oBUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Scoreboard bench for uart_rx_cmd: stimulus pushes expected pulses, a negedge
// monitor pops and checks kind, data and start-to-pulse latency.
module tb_uart_rx_cmd;

  localparam int CPB = 16;
  localparam int LAT = CPB / 2 + 9 * CPB;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       iRX;
  logic [7:0] odata;
  logic       oVALID;
  logic       oFRAME_ERR;
  logic       oBUSY;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  logic       prev_busy = 1'b0;
  logic [7:0] exp_odata = 8'h00;

  uart_rx_cmd #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .iRX        (iRX),
    .odata      (odata),
    .oVALID     (oVALID),
    .oFRAME_ERR (oFRAME_ERR),
    .oBUSY      (oBUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decoupled from stimulus, compares every pulse against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (oBUSY && !prev_busy) rise_cyc = cyc;
    prev_busy = oBUSY;
    if (oVALID || oFRAME_ERR) begin
      check("pulse_exclusive", {31'd0, oVALID & oFRAME_ERR}, 32'd0);
      check("pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pulse_kind", {31'd0, oFRAME_ERR}, {31'd0, e.is_err});
        check("odata", {24'd0, odata}, {24'd0, e.data});
        check("latency", cyc - rise_cyc, LAT);
      end
    end
  end

  task automatic push_byte(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_odata = d;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = exp_odata;
    sb.push_back(e);
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; leaves iRX at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    iRX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      iRX = d[i];
      repeat (CPB) @(negedge clk);
    end
    iRX = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4 * LAT && sb.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check(name, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    iRX   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_odata", {24'd0, odata}, 32'h00);
    check("rst_valid", {31'd0, oVALID}, 32'd0);
    check("rst_ferr", {31'd0, oFRAME_ERR}, 32'd0);
    check("rst_busy", {31'd0, oBUSY}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // T1: single 'M'
    push_byte(8'h4D);
    send_frame(8'h4D, 1'b1);
    wait_drain("t1_drain");

    // T2: 4-cycle glitch must be rejected
    iRX = 1'b0;
    repeat (4) @(negedge clk);
    iRX = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t2_busy", {31'd0, oBUSY}, 32'd0);
    check("t2_odata", {24'd0, odata}, {24'd0, exp_odata});

    // T3: bad stop bit, line held low 100 cycles
    push_err();
    send_frame(8'h46, 1'b0);
    repeat (100) @(negedge clk);
    check("t3_busy_held", {31'd0, oBUSY}, 32'd1);
    iRX = 1'b1;
    wait_drain("t3_drain");
    check("t3_busy_released", {31'd0, oBUSY}, 32'd0);
    check("t3_odata", {24'd0, odata}, 32'h4D);

    // T4: back-to-back rate characters
    push_byte(8'h31);
    push_byte(8'h41);
    push_byte(8'h35);
    send_frame(8'h31, 1'b1);
    send_frame(8'h41, 1'b1);
    send_frame(8'h35, 1'b1);
    wait_drain("t4_drain");
    check("t4_odata", {24'd0, odata}, 32'h35);

    // T5: reset in the middle of the data bits of 0x66
    iRX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      iRX = (8'h66 >> i) & 8'h01;
      repeat (CPB) @(negedge clk);
    end
    reset = 1'b0;
    #1;
    exp_odata = 8'h00;
    check("t5_rst_odata", {24'd0, odata}, 32'h00);
    check("t5_rst_valid", {31'd0, oVALID}, 32'd0);
    check("t5_rst_ferr", {31'd0, oFRAME_ERR}, 32'd0);
    check("t5_rst_busy", {31'd0, oBUSY}, 32'd0);
    iRX = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    push_byte(8'h63);
    send_frame(8'h63, 1'b1);
    wait_drain("t5_drain");

    // T6: all-ones then all-zeros data
    push_byte(8'hFF);
    send_frame(8'hFF, 1'b1);
    wait_drain("t6a_drain");
    check("t6a_odata", {24'd0, odata}, 32'hFF);
    push_byte(8'h00);
    send_frame(8'h00, 1'b1);
    wait_drain("t6b_drain");
    check("t6b_odata", {24'd0, odata}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
